// File: rtl/y86_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | y86_pkg                                                              |
// | Y86 status codes and the data-memory responder state encoding.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package y86_pkg;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2,
    RESP = 2'd3
  } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_lane_align                                                      |
// | Byte-lane steering for 8-byte accesses spanning two 64-bit words.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dmem_lane_align (
  input  logic [2:0]  off,
  input  logic [63:0] wordLo,
  input  logic [63:0] wordHi,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic [7:0]  beLo,
  output logic [7:0]  beHi,
  output logic [63:0] wdLo,
  output logic [63:0] wdHi
);

  logic [127:0] wPair;
  logic [127:0] wShiftedData;
  logic [15:0]  wShiftedBe;

  always_comb begin
    wPair        = {wordHi, wordLo} >> (8 * off);
    wShiftedData = {64'd0, wdata} << (8 * off);
    wShiftedBe   = {8'd0, 8'hFF} << off;
    rdata        = wPair[63:0];
    wdLo         = wShiftedData[63:0];
    wdHi         = wShiftedData[127:64];
    beLo         = wShiftedBe[7:0];
    beHi         = wShiftedBe[15:8];
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder                                                       |
// | Memory-stage data responder: 8-byte LE accesses, split when unaligned.|
// | Optional macro DMEM_ALIGN_CHECK_EN rejects unaligned accesses (SADR). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dmem_responder
  import y86_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic [2:0]  rsp_stat_o,
  output logic        busy_o
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam int          CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [64:0] LAST_ADDR = 65'(DEPTH) * 65'd8 - 65'd1;

  dmem_state_t      rState, wNext;
  logic [63:0]      rMem [DEPTH];
  logic [IDX_W-1:0] rIdx, wIdx;
  logic [2:0]       rOff;
  logic             rWrite;
  logic [63:0]      rWdata;
  logic [CNT_W-1:0] rWaitCnt;
  logic             rRspValid;
  logic [63:0]      rRdata;
  logic [2:0]       rStat;

  logic             wOutOfRange, wBadReq, wPhaseDone, wAccess;
  logic [63:0]      wWord, wLo, wHi, wRdata, wWdLo, wWdHi, wWrData;
  logic [7:0]       wBeLo, wBeHi, wWrBe;

  // 65-bit sum so that an address near 2^64 wrapping past zero is rejected.
  assign wOutOfRange = ({1'b0, req_addr_i} + 65'd7) > LAST_ADDR;
`ifdef DMEM_ALIGN_CHECK_EN
  assign wBadReq     = wOutOfRange || (req_addr_i[2:0] != 3'd0);
`else
  assign wBadReq     = wOutOfRange;
`endif

  assign wPhaseDone  = (rWaitCnt == CNT_W'(WAIT_CYCLES));
  assign wAccess     = ((rState == PH1) || (rState == PH2)) && wPhaseDone;
  assign wWord       = rMem[wIdx];

`ifdef DMEM_ALIGN_CHECK_EN
  assign wIdx    = rIdx;
  assign wLo     = wWord;
  assign wHi     = 64'd0;
  assign wWrBe   = wBeLo;
  assign wWrData = wWdLo;
`else
  logic [63:0] rLo;
  // PH2 merges the word captured in PH1 with the word k+1 read now.
  assign wIdx    = (rState == PH2) ? rIdx + IDX_W'(1) : rIdx;
  assign wLo     = (rState == PH2) ? rLo : wWord;
  assign wHi     = (rState == PH2) ? wWord : 64'd0;
  assign wWrBe   = (rState == PH2) ? wBeHi : wBeLo;
  assign wWrData = (rState == PH2) ? wWdHi : wWdLo;
`endif

  dmem_lane_align uAlign (
    .off    (rOff),
    .wordLo (wLo),
    .wordHi (wHi),
    .wdata  (rWdata),
    .rdata  (wRdata),
    .beLo   (wBeLo),
    .beHi   (wBeHi),
    .wdLo   (wWdLo),
    .wdHi   (wWdHi)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rState <= IDLE;
    else          rState <= wNext;
  end

  always_comb begin
    wNext = rState;
    case (rState)
      IDLE: if (req_valid_i) wNext = wBadReq ? RESP : PH1;
      PH1: if (wPhaseDone) begin
`ifdef DMEM_ALIGN_CHECK_EN
        wNext = RESP;
`else
        wNext = (rOff == 3'd0) ? RESP : PH2;
`endif
      end
`ifndef DMEM_ALIGN_CHECK_EN
      PH2: if (wPhaseDone) wNext = RESP;
`endif
      RESP: if (rsp_ready_i) wNext = IDLE;
      default: wNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rIdx      <= '0;
      rOff      <= 3'd0;
      rWrite    <= 1'b0;
      rWdata    <= 64'd0;
      rWaitCnt  <= '0;
      rRspValid <= 1'b0;
      rRdata    <= 64'd0;
      rStat     <= SAOK;
`ifndef DMEM_ALIGN_CHECK_EN
      rLo       <= 64'd0;
`endif
    end else begin
      if (rState == IDLE && req_valid_i) begin
        rIdx   <= req_addr_i[IDX_W+2:3];
        rOff   <= req_addr_i[2:0];
        rWrite <= req_write_i;
        rWdata <= req_wdata_i;
      end
      if (rState == PH1 || rState == PH2)
        rWaitCnt <= wPhaseDone ? '0 : rWaitCnt + CNT_W'(1);
      else
        rWaitCnt <= '0;
`ifndef DMEM_ALIGN_CHECK_EN
      if (rState == PH1 && wPhaseDone) rLo <= wWord;
`endif
      // Response is loaded once on entry to RESP and then held.
      if (rState != RESP && wNext == RESP) begin
        rRspValid <= 1'b1;
        if (rState == IDLE) begin
          rRdata <= 64'd0;
          rStat  <= SADR;
        end else begin
          rRdata <= rWrite ? 64'd0 : wRdata;
          rStat  <= SAOK;
        end
      end else if (rState == RESP && rsp_ready_i) begin
        rRspValid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wAccess && rWrite) begin
      for (int b = 0; b < 8; b++) begin
        if (wWrBe[b]) rMem[wIdx][8*b +: 8] <= wWrData[8*b +: 8];
      end
    end
  end

  assign req_ready_o = (rState == IDLE);
  assign busy_o      = (rState != IDLE);
  assign rsp_valid_o = rRspValid;
  assign rsp_rdata_o = rRdata;
  assign rsp_stat_o  = rStat;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_responder                                                    |
// | Two responders (WAIT_CYCLES 0 and 2) against a byte-level memory model.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int NBYTE = DEPTH * 8;
  localparam int W0    = 0;
  localparam int W1    = 2;

  logic        clk = 1'b0;
  logic        rstN;
  logic        sel;
  logic        reqValid, reqWrite, rspReady;
  logic [63:0] reqAddr, reqWdata;

  logic        rr0, rv0, bz0, rr1, rv1, bz1;
  logic [63:0] rd0, rd1;
  logic [2:0]  st0, st1;

  logic        reqReady, rspValid, busy;
  logic [63:0] rspRdata;
  logic [2:0]  rspStat;

  logic [7:0]  mb [2][NBYTE];
  int          nPass = 0;
  int          nTotal = 0;

  always #5 clk = ~clk;

  assign reqReady = sel ? rr1 : rr0;
  assign rspValid = sel ? rv1 : rv0;
  assign busy     = sel ? bz1 : bz0;
  assign rspRdata = sel ? rd1 : rd0;
  assign rspStat  = sel ? st1 : st0;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W0)) dut0 (
    .clk_i(clk), .rst_n_i(rstN), .req_valid_i(reqValid & ~sel), .req_ready_o(rr0),
    .req_write_i(reqWrite), .req_addr_i(reqAddr), .req_wdata_i(reqWdata),
    .rsp_valid_o(rv0), .rsp_ready_i(rspReady), .rsp_rdata_o(rd0), .rsp_stat_o(st0), .busy_o(bz0)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W1)) dut1 (
    .clk_i(clk), .rst_n_i(rstN), .req_valid_i(reqValid & sel), .req_ready_o(rr1),
    .req_write_i(reqWrite), .req_addr_i(reqAddr), .req_wdata_i(reqWdata),
    .rsp_valid_o(rv1), .rsp_ready_i(rspReady), .rsp_rdata_o(rd1), .rsp_stat_o(st1), .busy_o(bz1)
  );

  // Full transaction on responder s, with expectations from the byte model.
  task automatic run_op(input int s, input bit wr, input logic [63:0] addr, input logic [63:0] wd);
    logic [64:0] last;
    logic [63:0] expD;
    logic [2:0]  expS;
    bit          bad;
    int          lat, expL, w, base;
    w    = (s != 0) ? W1 : W0;
    last = {1'b0, addr} + 65'd7;
    bad  = (last > 65'(NBYTE - 1));
`ifdef DMEM_ALIGN_CHECK_EN
    if (addr[2:0] != 3'd0) bad = 1'b1;
`endif
    expD = 64'd0;
    expS = bad ? 3'd3 : 3'd1;
    if (!bad) begin
      base = int'(addr[12:0]);
      for (int b = 0; b < 8; b++) begin
        if (wr) mb[s][base+b] = wd[8*b +: 8];
        else    expD[8*b +: 8] = mb[s][base+b];
      end
    end
    expL = bad ? 1 : ((addr[2:0] == 3'd0) ? w + 2 : 2 * w + 3);

    sel = (s != 0); reqWrite = wr; reqAddr = addr; reqWdata = wd; reqValid = 1'b1;
    #1;
    nTotal++; if (reqReady !== 1'b1) $display("FAIL req_ready_idle: got %b want 1", reqReady); else nPass++;
    @(posedge clk); #1;
    reqValid = 1'b0; reqAddr = {$urandom, $urandom}; reqWdata = {$urandom, $urandom};
    lat = 1;
    while (rspValid !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    nTotal++; if (rspValid !== 1'b1) $display("FAIL rsp_timeout addr=%h: got valid %b want 1", addr, rspValid); else nPass++;
    nTotal++; if (lat != expL) $display("FAIL latency dut%0d addr=%h: got %0d want %0d", s, addr, lat, expL); else nPass++;
    nTotal++; if (rspStat !== expS) $display("FAIL stat addr=%h: got %0d want %0d", addr, rspStat, expS); else nPass++;
    nTotal++; if (rspRdata !== expD) $display("FAIL rdata dut%0d addr=%h wr=%b: got %h want %h", s, addr, wr, rspRdata, expD); else nPass++;
    nTotal++; if (busy !== 1'b1 || reqReady !== 1'b0) $display("FAIL busy_in_resp: got busy=%b ready=%b want 1/0", busy, reqReady); else nPass++;
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;
    nTotal++; if (rspValid !== 1'b0 || reqReady !== 1'b1 || busy !== 1'b0)
      $display("FAIL after_handshake: got valid=%b ready=%b busy=%b want 0/1/0", rspValid, reqReady, busy); else nPass++;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = (s != 0); #1;
      nTotal++; if (reqReady !== 1'b1) $display("FAIL reset_ready dut%0d: got %b want 1", s, reqReady); else nPass++;
      nTotal++; if (rspValid !== 1'b0) $display("FAIL reset_valid dut%0d: got %b want 0", s, rspValid); else nPass++;
      nTotal++; if (rspRdata !== 64'd0) $display("FAIL reset_rdata dut%0d: got %h want 0", s, rspRdata); else nPass++;
      nTotal++; if (rspStat !== 3'd1) $display("FAIL reset_stat dut%0d: got %0d want 1", s, rspStat); else nPass++;
      nTotal++; if (busy !== 1'b0) $display("FAIL reset_busy dut%0d: got %b want 0", s, busy); else nPass++;
    end
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_preload();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 72; k++) run_op(s, 1'b1, 64'(k * 8), {$urandom, $urandom});
      for (int k = DEPTH - 4; k < DEPTH; k++) run_op(s, 1'b1, 64'(k * 8), {$urandom, $urandom});
    end
  endtask

  task automatic test_directed();
    run_op(0, 1'b1, 64'h10, 64'h1122334455667788);
    run_op(0, 1'b0, 64'h10, 64'h0);
    run_op(0, 1'b1, 64'h0D, 64'hA1A2A3A4A5A6A7A8);
    run_op(0, 1'b0, 64'h08, 64'h0);
    run_op(0, 1'b0, 64'h10, 64'h0);
    run_op(0, 1'b0, 64'h0D, 64'h0);
    run_op(0, 1'b0, 64'h1FF8, 64'h0);
    run_op(0, 1'b0, 64'h1FF9, 64'h0);
    run_op(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEADBEEFCAFEF00D);
    run_op(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    run_op(0, 1'b0, 64'h0, 64'h0);
    run_op(0, 1'b0, 64'h1FF8, 64'h0);
    run_op(1, 1'b1, 64'h40, 64'h0123456789ABCDEF);
    run_op(1, 1'b1, 64'h43, 64'hFEDCBA9876543210);
    run_op(1, 1'b0, 64'h40, 64'h0);
    run_op(1, 1'b0, 64'h48, 64'h0);
  endtask

  task automatic test_backpressure();
    logic [63:0] expD, capD;
    logic [2:0]  capS;
    int          n;
    for (int b = 0; b < 8; b++) expD[8*b +: 8] = mb[0][32+b];
    sel = 1'b0; reqWrite = 1'b0; reqAddr = 64'h20; reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    n = 0;
    while (rspValid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    capD = rspRdata; capS = rspStat;
    nTotal++; if (capD !== expD) $display("FAIL bp_rdata: got %h want %h", capD, expD); else nPass++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      nTotal++; if (rspValid !== 1'b1 || rspRdata !== expD || rspStat !== 3'd1 || reqReady !== 1'b0)
        $display("FAIL bp_hold cycle %0d: got valid=%b rdata=%h stat=%0d ready=%b want 1/%h/1/0",
                 c, rspValid, rspRdata, rspStat, reqReady, expD); else nPass++;
    end
    rspReady = 1'b1;
    reqValid = 1'b1; reqAddr = 64'h10;
    for (int b = 0; b < 8; b++) expD[8*b +: 8] = mb[0][16+b];
    @(posedge clk); #1;
    rspReady = 1'b0;
    nTotal++; if (rspValid !== 1'b0 || reqReady !== 1'b1) $display("FAIL bp_release: got valid=%b ready=%b want 0/1", rspValid, reqReady); else nPass++;
    @(posedge clk); #1;
    reqValid = 1'b0;
    nTotal++; if (busy !== 1'b1) $display("FAIL bp_next_accept: got busy=%b want 1", busy); else nPass++;
    n = 0;
    while (rspValid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    nTotal++; if (rspRdata !== expD) $display("FAIL bp_next_rdata: got %h want %h", rspRdata, expD); else nPass++;
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] a;
    int          r;
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      a = 64'($urandom_range(0, 64 * 8 - 8));
      else if (r < 9) a = 64'($urandom_range(NBYTE - 32, NBYTE + 4));
      else            a = {$urandom, $urandom};
      run_op(int'($urandom_range(0, 1)), 1'($urandom), a, {$urandom, $urandom});
    end
  endtask

  task automatic test_reset_mid();
`ifndef DMEM_ALIGN_CHECK_EN
    sel = 1'b1; reqWrite = 1'b1; reqAddr = 64'h25; reqWdata = {$urandom, $urandom}; reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    repeat (W1 + 1) @(posedge clk);
    #1;
    nTotal++; if (busy !== 1'b1 || rspValid !== 1'b0) $display("FAIL mid_busy: got busy=%b valid=%b want 1/0", busy, rspValid); else nPass++;
    #2 rstN = 1'b0;
    #1;
    nTotal++; if (reqReady !== 1'b1 || rspValid !== 1'b0) $display("FAIL mid_reset: got ready=%b valid=%b want 1/0", reqReady, rspValid); else nPass++;
    @(posedge clk); #1;
    nTotal++; if (reqReady !== 1'b1 || busy !== 1'b0) $display("FAIL mid_reset_held: got ready=%b busy=%b want 1/0", reqReady, busy); else nPass++;
    rstN = 1'b1;
    @(posedge clk); #1;
    run_op(1, 1'b1, 64'h20, {$urandom, $urandom});
    run_op(1, 1'b1, 64'h28, {$urandom, $urandom});
    run_op(1, 1'b0, 64'h25, 64'h0);
`endif
  endtask

  initial begin
    rstN = 1'b0; sel = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; rspReady = 1'b0;
    reqAddr = 64'd0; reqWdata = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_preload();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the pipeline's memory-stage request interface.
- Accepts one read or write request at a time over a valid/ready handshake.
- Serves 8-byte little-endian accesses from an internal word array; an unaligned access is split into two word phases.
- Returns read data plus a Y86 status code (SAOK/SADR) over a valid/ready response channel. The memory stage stalls on its busy/handshake signals.

Parameters:
- DEPTH, 1024, number of 64-bit words in the array (byte space 0 .. DEPTH*8-1).
- WAIT_CYCLES, 0, extra wait cycles per word phase (0 = single-cycle phase).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  64  byte address.
- req_wdata_i  in  64  write data, little-endian.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  requester accepts the response.
- rsp_rdata_o  out  64  read data (0 for writes and errors).
- rsp_stat_o  out  3  status: SAOK=3'd1, SADR=3'd3.
- busy_o  out  1  a request is accepted and its response has not yet completed.

Behaviour:
- Clock and reset: single clock clk_i; rst_n_i is asynchronous and active-low.
- Reset values: FSM=IDLE, req_ready_o=1 (combinational from IDLE), rsp_valid_o=0, rsp_rdata_o=0, rsp_stat_o=SAOK, busy_o=0, wait counter=0. Array contents are not reset.
- Reset asserted mid-operation: aborts the access. A partially done split write may leave word k updated and word k+1 not; this is permitted.
- FSM states: IDLE, PH1, PH2, RESP.
- Request acceptance: a request is accepted on an edge where req_valid_i && req_ready_o. req_ready_o is high only in IDLE. Address, write flag and data are captured on acceptance.
- Address split: k = addr[63:3], offset o = addr[2:0].
- Range check: computed in 65 bits, so wrap-around of addr+7 counts as out of range. If addr+7 > DEPTH*8-1, go IDLE→RESP directly: stat=SADR, rdata=0, no array write.
- IDLE→PH1 for in-range requests.
- PH1: lasts WAIT_CYCLES+1 cycles. On its last cycle word k is accessed. If o==0, go to RESP; otherwise go to PH2.
- PH2: lasts WAIT_CYCLES+1 cycles; word k+1 is accessed on its last cycle; then go to RESP.
- Read merge: rdata = {word[k+1], word[k]} >> (8*o), low 64 bits.
- Aligned write: word[k] = wdata.
- Split write: PH1 writes bytes o..7 of word k with wdata bytes 0..7-o. PH2 writes bytes 0..o-1 of word k+1 with wdata bytes 8-o..7. Other bytes are preserved.
- RESP: rsp_valid_o is registered high. rsp_valid_o, rdata and stat are held stable until rsp_ready_i. On the handshake edge go to IDLE and drop rsp_valid_o. Back-to-back operation: a new request can be accepted on the cycle after the handshake.
- Latency, measured from the acceptance edge to the first rsp_valid_o cycle:
  - aligned: WAIT_CYCLES+2 edges.
  - split: 2*WAIT_CYCLES+3 edges.
  - SADR: 1 edge.
- busy_o = (state != IDLE).
- Inputs are ignored outside IDLE.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: any in-range request with o != 0 is treated like out-of-range: IDLE→RESP, stat=SADR, rdata=0, no write. PH2 logic is compiled out.
- Undefined: unaligned accesses are split as described above.

Decomposition:
- Shared package y86_pkg: status codes SAOK/SHLT/SADR/SINS (3-bit) and the FSM state enum dmem_state_t.
- One combinational sub-module, dmem_lane_align: given o, the two words and wdata, it produces the merged read data and the per-word byte enables and shifted write data.
- The FSM, counter and array stay in dmem_responder.

Test Plan:
- WAIT_CYCLES=0: write addr 0x10 data 0x1122334455667788, then read 0x10 → rdata 0x1122334455667788, SAOK; each response arrives 2 edges after acceptance.
- Split write addr 0x0D data 0xA1A2A3A4A5A6A7A8, then read 0x08 and 0x10 → word1 bytes 5..7 = A8,A7,A6 and word2 bytes 0..4 = A5..A1; other bytes unchanged. Read at 0x0D returns the original data; latency is 3 edges.
- DEPTH=1024, read addr 0x1FF9 → SADR, rdata 0, 1-edge latency. Read addr 0xFFFF_FFFF_FFFF_FFFC (wraps) → SADR; the array is unmodified.
- Backpressure: hold rsp_ready_i=0 for 5 cycles → rsp_valid_o, rdata and stat stay stable and req_ready_o stays 0; one cycle after rsp_ready_i=1 the responder accepts the next request.
- WAIT_CYCLES=2: aligned latency is 4 edges and split latency is 7; deassert rst_n_i during PH2 → next cycle req_ready_o=1, rsp_valid_o=0.
- DMEM_ALIGN_CHECK_EN defined: read addr 0x0D → SADR, 1-edge latency, no array change.
